// File: rtl/thread_scheduler.sv
// Barrel-thread issue scheduler: picks the fetching thread each cycle and
// supplies its PC, tracking per-thread PC, active and blocked state.
// Optional macro SCHED_STRICT_BARREL_EN selects a fixed-slot barrel (bubbles on
// non-ready slots); when undefined, a skip-ahead round-robin is used.
module thread_scheduler #(
   parameter int unsigned                ADDRESS_WIDTH = 32,
   parameter int unsigned                NUM_THREADS   = 4,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
   localparam int unsigned               BITS_THREADS  = $clog2(NUM_THREADS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [NUM_THREADS-1:0]   start_mask,
   input  logic                     stall,
   input  logic                     redirect_valid,
   input  logic [BITS_THREADS-1:0]  redirect_tid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   input  logic                     halt_valid,
   input  logic [BITS_THREADS-1:0]  halt_tid,
   input  logic                     wait_set,
   input  logic [BITS_THREADS-1:0]  wait_set_tid,
   input  logic                     wait_clr,
   input  logic [BITS_THREADS-1:0]  wait_clr_tid,
   output logic                     issue_valid,
   output logic [BITS_THREADS-1:0]  issue_tid,
   output logic [ADDRESS_WIDTH-1:0] issue_pc,
   output logic [NUM_THREADS-1:0]   active_mask,
   output logic                     busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [NUM_THREADS-1:0]   active_q, active_d;
   logic [NUM_THREADS-1:0]   blocked_q, blocked_d;
   logic [NUM_THREADS-1:0]   ready;
   logic                     consume;

   assign ready       = active_q & ~blocked_q;
   assign active_mask = active_q;
   assign busy        = (state_q == RUN);
   assign issue_pc    = pc_q[issue_tid];
   assign consume     = issue_valid & ~stall;

`ifdef SCHED_STRICT_BARREL_EN
   logic [BITS_THREADS-1:0] slot_q, slot_d;

   // Fixed slot: the slot's thread issues if ready, otherwise the slot is a bubble.
   always_comb begin
      issue_tid   = slot_q;
      issue_valid = (state_q == RUN) && ready[slot_q];
   end
`else
   logic [BITS_THREADS-1:0] last_q, last_d, cand;
   logic                    found;

   // Circular search for the first ready thread after the last consumed one.
   always_comb begin
      found     = 1'b0;
      cand      = '0;
      issue_tid = '0;
      for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
         // power-of-two thread count: wrap-around is plain truncation
         cand = last_q + BITS_THREADS'(k);
         if (!found && ready[cand]) begin
            found     = 1'b1;
            issue_tid = cand;
         end
      end
      issue_valid = found && (state_q == RUN);
   end
`endif

   // Next-state: consumed issue, pipeline events, and start/finish of a run.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      active_d  = active_q;
      blocked_d = blocked_q;
`ifdef SCHED_STRICT_BARREL_EN
      slot_d    = slot_q;
      if (state_q == RUN && !stall) slot_d = slot_q + 1'b1;
`else
      last_d    = last_q;
      if (consume) last_d = issue_tid;
`endif
      if (consume) pc_d[issue_tid] = pc_q[issue_tid] + ADDRESS_WIDTH'(4);
      // redirect is applied after the +4 so it wins on the same thread
      if (redirect_valid) pc_d[redirect_tid] = redirect_pc;
      if (halt_valid)     active_d[halt_tid] = 1'b0;
      // clear before set so a same-tid collision leaves the thread blocked
      if (wait_clr)       blocked_d[wait_clr_tid] = 1'b0;
      if (wait_set)       blocked_d[wait_set_tid] = 1'b1;

      case (state_q)
         IDLE: begin
            if (start && start_mask != '0) begin
               state_d   = RUN;
               active_d  = start_mask;
               blocked_d = '0;
               for (int unsigned i = 0; i < NUM_THREADS; i++) pc_d[i] = RESET_PC;
`ifdef SCHED_STRICT_BARREL_EN
               slot_d    = '0;
`else
               last_d    = BITS_THREADS'(NUM_THREADS - 1);
`endif
            end
         end
         RUN: begin
            if (active_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         active_q  <= '0;
         blocked_q <= '0;
         for (int unsigned i = 0; i < NUM_THREADS; i++) pc_q[i] <= RESET_PC;
`ifdef SCHED_STRICT_BARREL_EN
         slot_q    <= '0;
`else
         last_q    <= BITS_THREADS'(NUM_THREADS - 1);
`endif
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         blocked_q <= blocked_d;
         pc_q      <= pc_d;
`ifdef SCHED_STRICT_BARREL_EN
         slot_q    <= slot_d;
`else
         last_q    <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
// Honours SCHED_STRICT_BARREL_EN in the model when the build defines it.
module tb_thread_scheduler;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  start_mask;
   logic        stall;
   logic        redirect_valid;
   logic [1:0]  redirect_tid;
   logic [31:0] redirect_pc;
   logic        halt_valid;
   logic [1:0]  halt_tid;
   logic        wait_set;
   logic [1:0]  wait_set_tid;
   logic        wait_clr;
   logic [1:0]  wait_clr_tid;
   logic        issue_valid;
   logic [1:0]  issue_tid;
   logic [31:0] issue_pc;
   logic [3:0]  active_mask;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   thread_scheduler #(
      .ADDRESS_WIDTH(32),
      .NUM_THREADS  (4),
      .RESET_PC     (32'h0000_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_mask(start_mask), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
      .halt_valid(halt_valid), .halt_tid(halt_tid),
      .wait_set(wait_set), .wait_set_tid(wait_set_tid),
      .wait_clr(wait_clr), .wait_clr_tid(wait_clr_tid),
      .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
      .active_mask(active_mask), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc [N];
   bit          m_act [N];
   bit          m_blk [N];
   int          m_last;
   int          m_slot;
   bit          m_run;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_pc[i] = 0; m_act[i] = 0; m_blk[i] = 0; end
      m_last = N - 1; m_slot = 0; m_run = 0;
   endtask

   function automatic bit m_ready(int t);
      return m_act[t] && !m_blk[t];
   endfunction

   task automatic model_sel(output bit v, output int t);
      v = 0; t = 0;
`ifdef SCHED_STRICT_BARREL_EN
      t = m_slot;
      v = m_run && m_ready(m_slot);
`else
      if (m_run) begin
         for (int k = 1; k <= N; k++) begin
            if (!v && m_ready((m_last + k) % N)) begin v = 1; t = (m_last + k) % N; end
         end
      end
`endif
   endtask

   task automatic model_step();
      bit v; int t; bit any;
      model_sel(v, t);
      if (!m_run) begin
         if (start && start_mask != 0) begin
            for (int i = 0; i < N; i++) begin m_act[i] = start_mask[i]; m_blk[i] = 0; m_pc[i] = 0; end
            m_last = N - 1; m_slot = 0; m_run = 1;
            return;
         end
      end else begin
         any = 0;
         for (int i = 0; i < N; i++) any |= m_act[i];
         if (!any) m_run = 0;
         if (!stall) m_slot = (m_slot + 1) % N;
         if (v && !stall) begin m_pc[t] = m_pc[t] + 4; m_last = t; end
      end
      if (redirect_valid) m_pc[redirect_tid] = redirect_pc;
      if (halt_valid) m_act[halt_tid] = 0;
      if (wait_set) m_blk[wait_set_tid] = 1;
      else if (wait_clr) m_blk[wait_clr_tid] = 0;
      if (wait_set && wait_clr && wait_set_tid != wait_clr_tid) m_blk[wait_clr_tid] = 0;
   endtask

   function automatic logic [3:0] m_actmask();
      logic [3:0] m;
      for (int i = 0; i < N; i++) m[i] = m_act[i];
      return m;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Compare against the model mid-cycle, clock once, advance the model.
   task automatic tick();
      bit v; int t;
      #1;
      model_sel(v, t);
      chk("model_valid", {31'b0, issue_valid}, {31'b0, v});
      if (v) begin
         chk("model_tid", {30'b0, issue_tid}, t);
         chk("model_pc", issue_pc, m_pc[t]);
      end
      chk("model_active", {28'b0, active_mask}, {28'b0, m_actmask()});
      chk("model_busy", {31'b0, busy}, {31'b0, m_run});
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clr_in();
      start = 0; start_mask = 0; stall = 0;
      redirect_valid = 0; redirect_tid = 0; redirect_pc = 0;
      halt_valid = 0; halt_tid = 0;
      wait_set = 0; wait_set_tid = 0; wait_clr = 0; wait_clr_tid = 0;
   endtask

   task automatic do_reset();
      clr_in();
      @(negedge clk);
      rst_n = 0;
      #12;
      rst_n = 1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic start_all(logic [3:0] m);
      start = 1; start_mask = m;
      tick();
      start = 0; start_mask = 0;
   endtask

   typedef struct {
      bit          st;
      logic [3:0]  sm;
      bit          stl;
      bit          ev;
      int          et;
      logic [31:0] ep;
   } vec_t;

   vec_t tbl [11];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt3;
      logic [3:0] am;

      rst_n = 0;
      clr_in();
      model_reset();
      #13;
      // reset state, observed while reset is still held
      chk("rst_valid", {31'b0, issue_valid}, 0);
      chk("rst_tid",   {30'b0, issue_tid}, 0);
      chk("rst_busy",  {31'b0, busy}, 0);
      chk("rst_active", {28'b0, active_mask}, 0);
      rst_n = 1;
      @(posedge clk); #1;

      // ---- table: start 1111, 8 issues, then a stalled cycle ----
      tbl[0]  = '{1, 4'hF, 0, 0, 0, 32'h0};
      tbl[1]  = '{0, 4'h0, 0, 1, 0, 32'h0};
      tbl[2]  = '{0, 4'h0, 0, 1, 1, 32'h0};
      tbl[3]  = '{0, 4'h0, 0, 1, 2, 32'h0};
      tbl[4]  = '{0, 4'h0, 0, 1, 3, 32'h0};
      tbl[5]  = '{0, 4'h0, 0, 1, 0, 32'h4};
      tbl[6]  = '{0, 4'h0, 0, 1, 1, 32'h4};
      tbl[7]  = '{0, 4'h0, 0, 1, 2, 32'h4};
      tbl[8]  = '{0, 4'h0, 0, 1, 3, 32'h4};
      tbl[9]  = '{0, 4'h0, 1, 1, 0, 32'h8};
      tbl[10] = '{0, 4'h0, 0, 1, 0, 32'h8};
      for (int i = 0; i < 11; i++) begin
         start = tbl[i].st; start_mask = tbl[i].sm; stall = tbl[i].stl;
         chk("tbl_valid", {31'b0, issue_valid}, {31'b0, tbl[i].ev});
         if (tbl[i].ev) begin
            chk("tbl_tid", {30'b0, issue_tid}, tbl[i].et);
            chk("tbl_pc", issue_pc, tbl[i].ep);
            chk("tbl_busy", {31'b0, busy}, 1);
         end
         tick();
      end
      clr_in();

      // ---- mask 0101 with wait_set / wait_clr on tid 2 ----
      do_reset();
      start_all(4'b0101);
`ifndef SCHED_STRICT_BARREL_EN
      chk("w_tid0", {30'b0, issue_tid}, 0); chk("w_pc0", issue_pc, 0);
      tick();
      chk("w_tid2", {30'b0, issue_tid}, 2); chk("w_pc2", issue_pc, 0);
      wait_set = 1; wait_set_tid = 2;
      tick(); clr_in();
      for (int i = 1; i <= 3; i++) begin
         chk("w_blk_tid", {30'b0, issue_tid}, 0);
         chk("w_blk_pc", issue_pc, 32'(4 * i));
         if (i < 3) tick();
      end
      wait_clr = 1; wait_clr_tid = 2;
      tick(); clr_in();
      chk("w_resume_tid", {30'b0, issue_tid}, 2);
      chk("w_resume_pc", issue_pc, 32'h4);
`else
      tick();
      wait_set = 1; wait_set_tid = 2;
      tick(); clr_in();
      for (int i = 0; i < 8; i++) tick();
      wait_clr = 1; wait_clr_tid = 2;
      tick(); clr_in();
      for (int i = 0; i < 8; i++) tick();
`endif

      // ---- redirect on the consumed thread, then a 3-cycle stall ----
      do_reset();
      start_all(4'hF);
      tick();
      redirect_valid = 1; redirect_tid = 1; redirect_pc = 32'h100;
      tick(); clr_in();
      tick(); tick(); tick();
      chk("rd_tid", {30'b0, issue_tid}, 1);
      chk("rd_pc", issue_pc, 32'h100);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_tid", {30'b0, issue_tid}, 1);
         chk("stall_pc", issue_pc, 32'h100);
      end
      clr_in();

      // ---- halt every thread, fall back to IDLE, restart tid 1 ----
      do_reset();
      start_all(4'hF);
      for (int i = 0; i < N; i++) begin
         halt_valid = 1; halt_tid = 2'(i);
         tick();
         chk("halt_active", {28'b0, active_mask}, {28'b0, 4'hF << (i + 1)});
      end
      clr_in();
      chk("halt_busy_run", {31'b0, busy}, 1);
      tick();
      chk("halt_idle_busy", {31'b0, busy}, 0);
      chk("halt_idle_valid", {31'b0, issue_valid}, 0);
      start_all(4'b0010);
      chk("restart_active", {28'b0, active_mask}, 4'b0010);
      chk("restart_busy", {31'b0, busy}, 1);
`ifndef SCHED_STRICT_BARREL_EN
      chk("restart_tid", {30'b0, issue_tid}, 1);
      chk("restart_pc", issue_pc, 0);
`else
      tick();
      chk("restart_tid", {30'b0, issue_tid}, 1);
      chk("restart_pc", issue_pc, 0);
`endif

      // ---- asynchronous reset mid-run ----
      do_reset();
      start_all(4'hF);
      for (int i = 0; i < 5; i++) tick();
      wait_set = 1; wait_set_tid = 3;
      tick(); clr_in();
      #3;
      rst_n = 0;
      #1;
      chk("arst_valid", {31'b0, issue_valid}, 0);
      chk("arst_busy", {31'b0, busy}, 0);
      chk("arst_active", {28'b0, active_mask}, 0);
      chk("arst_tid", {30'b0, issue_tid}, 0);
      #10;
      rst_n = 1;
      model_reset();
      @(posedge clk); #1;
      chk("arst_pc", issue_pc, 0);
      start_all(4'hF);
      chk("arst_restart_pc", issue_pc, 0);

      // ---- same-tid wait_set/wait_clr, start ignored in RUN ----
      do_reset();
      start_all(4'hF);
      wait_set = 1; wait_set_tid = 3; wait_clr = 1; wait_clr_tid = 3;
      tick(); clr_in();
      cnt3 = 0;
      for (int i = 0; i < 8; i++) begin
         if (issue_valid && issue_tid == 2'd3) cnt3++;
         tick();
      end
      chk("collide_blocked_issues", cnt3, 0);
      am = active_mask;
      start = 1; start_mask = 4'b0001;
      tick(); clr_in();
      chk("start_in_run_active", {28'b0, active_mask}, 4'hF);
      chk("start_in_run_busy", {31'b0, busy}, 1);
      am = am;

      // ---- randomized traffic against the model ----
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         clr_in();
         if (!m_run) begin
            if ($urandom_range(3) == 0) begin start = 1; start_mask = 4'($urandom); end
         end else if ($urandom_range(49) == 0) begin
            start = 1; start_mask = 4'($urandom);
         end
         stall          = ($urandom_range(3) == 0);
         redirect_valid = ($urandom_range(5) == 0);
         redirect_tid   = 2'($urandom);
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
         halt_valid     = ($urandom_range(39) == 0);
         halt_tid       = 2'($urandom);
         wait_set       = ($urandom_range(7) == 0);
         wait_set_tid   = 2'($urandom);
         wait_clr       = ($urandom_range(2) == 0);
         wait_clr_tid   = 2'($urandom);
         tick();
      end
      clr_in();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Barrel-thread issue scheduler at the head of the pipeline; picks which hardware thread fetches each cycle and supplies its PC.
- Holds one PC per thread plus per-thread active and blocked state.
- Consumes redirect, halt and wait/wake events from later stages, which are tagged with tid as they travel down to writeback.
- Its issue_tid is the tid carried through the pipeline.

Parameters:
ADDRESS_WIDTH, 32, PC width
NUM_THREADS, 4, hardware thread count; power of two, >= 2
RESET_PC, 32'h0000_0000, PC loaded into every thread at reset and at start
(local) BITS_THREADS = $clog2(NUM_THREADS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; launch threads selected by start_mask
start_mask  in  NUM_THREADS  threads to activate on start
stall  in  1  front-end stall; no issue is consumed this cycle
redirect_valid  in  1  branch/jump redirect
redirect_tid  in  BITS_THREADS  thread to redirect
redirect_pc  in  ADDRESS_WIDTH  new PC
halt_valid  in  1  thread retires (ecall/ebreak)
halt_tid  in  BITS_THREADS  thread to halt
wait_set  in  1  block thread (long-latency op outstanding)
wait_set_tid  in  BITS_THREADS  thread to block
wait_clr  in  1  unblock thread
wait_clr_tid  in  BITS_THREADS  thread to unblock
issue_valid  out  1  issue_tid/issue_pc valid this cycle
issue_tid  out  BITS_THREADS  selected thread
issue_pc  out  ADDRESS_WIDTH  PC of selected thread
active_mask  out  NUM_THREADS  running threads
busy  out  1  state is RUN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all PCs=RESET_PC; active=0; blocked=0.
  - last_tid=NUM_THREADS-1; issue_valid=0, issue_tid=0, busy=0.
- FSM IDLE:
  - start with start_mask!=0: active<=start_mask, blocked<=0, PCs<=RESET_PC, last_tid<=NUM_THREADS-1, go RUN.
  - start with mask 0 is ignored.
- FSM RUN:
  - Goes to IDLE the cycle after active becomes 0.
  - start is ignored while in RUN.
- ready[i] = active[i] & ~blocked[i].
- Selection is combinational from registered state:
  - Search circularly from last_tid+1 for the first ready thread.
  - issue_valid=1 only in RUN with at least one ready thread.
  - issue_pc=pc[issue_tid]. Zero added latency: the output reflects the current state.
- Issue is consumed when issue_valid & ~stall:
  - pc[issue_tid] <= pc+4, modulo 2^ADDRESS_WIDTH.
  - last_tid <= issue_tid.
- When stall=1: no PC or pointer change; issue outputs stay stable for the same state.
- Redirect: pc[redirect_tid] <= redirect_pc. It takes priority over the +4 when it hits the thread being consumed the same cycle.
- Halt: active[halt_tid] <= 0 next cycle.
  - A same-cycle issue of that thread still occurs; downstream squashes it.
  - Redirect to a halted thread updates its PC only.
- Wait/wake:
  - wait_set sets blocked[tid]; wait_clr clears it.
  - Same tid in the same cycle: wait_set wins.
  - Clearing an unblocked thread is a no-op.
- All events are independent per thread; different tids may hit the same cycle.
- No starvation: each ready thread issues at least once every NUM_THREADS consumed issues.

Optional Feature:
SCHED_STRICT_BARREL_EN
- Defined:
  - Fixed-slot barrel. A slot counter (reset 0, reset to 0 on start) advances by 1 mod NUM_THREADS on every cycle in RUN with stall=0.
  - issue_tid=slot, and issue_valid=ready[slot].
  - A non-ready slot emits a bubble and is not skipped. This guarantees at most one instruction per thread in the pipe for NUM_THREADS stages.
- Undefined: skip-ahead round-robin as above.

Test Plan:
- Reset then start, mask 4'b1111, no stall, 8 cycles -> tids 0,1,2,3,0,1,2,3 with PCs 0,0,0,0,4,4,4,4; busy=1.
- Mask 4'b0101; wait_set tid 2 after its first issue -> only tid 0 issues (PCs 4,8,...); wait_clr tid 2 -> tid 2 resumes at PC 4. With STRICT_EN, bubbles in slots 1 and 3 throughout.
- Redirect tid 1 to 32'h100 in the same cycle tid 1 is consumed -> next tid 1 issue_pc=0x100, not 0x4; stall=1 for 3 cycles holds issue_tid/issue_pc unchanged.
- Halt tids 0..3 one per cycle -> active_mask decrements to 0, state IDLE, issue_valid=0, busy=0; a further start with mask 4'b0010 restarts tid 1 at RESET_PC.
- rst_n low mid-RUN with PCs nonzero and blocked set -> outputs clear immediately (asynchronously) and PCs read RESET_PC after release.
- wait_set and wait_clr same tid same cycle -> thread blocked; start asserted in RUN -> ignored, PCs unchanged.
